// File: rtl/io_bus_arbiter.sv
// ---------------------------------------------------------------------------
// io_bus_arbiter
//
// Purpose:
//   Shares the single memory-mapped IO bus (0x40000xxx) between NUM_MASTERS
//   bus masters. The arbiter is registered and round-robin. Each transaction
//   moves IDLE -> ACTIVE -> RESP -> IDLE. The winner's address, write data
//   and operation are latched toward the slave. The slave's ack and read data
//   are routed back to the winner as a one-cycle pulse.
//
// Handshake:
//   A master raises m_read_i[i] or m_write_i[i] and holds it, with stable
//   m_addr_i/m_wdata_i, until it sees m_ack_o[i]. It must drop the request
//   the cycle after m_ack_o. The slave holds off s_ack_i until it is done.
//   s_ack_i is honoured only while a transaction is ACTIVE. s_rdata_i is
//   valid in the same cycle as s_ack_i.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   m_read_i      per-master read request   [NUM_MASTERS]
//   m_write_i     per-master write request  [NUM_MASTERS]
//   m_addr_i      per-master address, master i at [32*i+31:32*i]
//   m_wdata_i     per-master write data, same packing
//   m_rdata_o     shared read data, valid with m_ack_o
//   m_ack_o       one-cycle completion pulse to the winner
//   m_err_o       one-cycle error pulse, coincident with m_ack_o
//   s_addr_o      slave address
//   s_wdata_o     slave write data
//   s_read_o      slave read strobe
//   s_write_o     slave write strobe
//   s_rdata_i     slave read data
//   s_ack_i       slave acknowledge
//   grant_o       one-hot current owner (0 in IDLE)
//   busy_o        high in ACTIVE and RESP
//
// Optional feature (macro IO_BUS_TIMEOUT_EN):
//   When the macro is defined, the arbiter counts ACTIVE cycles that pass
//   without s_ack_i. On the TIMEOUT_CYCLES-th such cycle it completes the
//   transaction with m_ack_o and m_err_o together and m_rdata_o = 32'hDEADBEEF.
//   When the macro is undefined, ACTIVE waits indefinitely and m_err_o is 0.
// ---------------------------------------------------------------------------
module io_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_MASTERS-1:0]   m_read_i,
    input  logic [NUM_MASTERS-1:0]   m_write_i,
    input  logic [NUM_MASTERS*32-1:0] m_addr_i,
    input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
    output logic [31:0]              m_rdata_o,
    output logic [NUM_MASTERS-1:0]   m_ack_o,
    output logic [NUM_MASTERS-1:0]   m_err_o,
    output logic [31:0]              s_addr_o,
    output logic [31:0]              s_wdata_o,
    output logic                     s_read_o,
    output logic                     s_write_o,
    input  logic [31:0]              s_rdata_i,
    input  logic                     s_ack_i,
    output logic [NUM_MASTERS-1:0]   grant_o,
    output logic                     busy_o
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // Reject unsupported configurations at elaboration time.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("io_bus_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [31:0]             s_addr_q, s_addr_d;
    logic [31:0]             s_wdata_q, s_wdata_d;
    logic                    s_read_q, s_read_d;
    logic                    s_write_q, s_write_d;
    logic [31:0]             m_rdata_q, m_rdata_d;
    logic [NUM_MASTERS-1:0]  m_ack_q, m_ack_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic                    busy_q, busy_d;

    logic [NUM_MASTERS-1:0]  req;
    logic                    win_found;
    logic [PTR_W-1:0]        win_idx;
    logic [PTR_W-1:0]        cand;
    logic [31:0]             sel_addr;
    logic [31:0]             sel_wdata;
    logic                    sel_read;
    logic                    sel_write;

`ifdef IO_BUS_TIMEOUT_EN
    // The counter is at least 8 bits and wide enough to reach TIMEOUT_CYCLES.
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [NUM_MASTERS-1:0]  m_err_q, m_err_d;
    logic                    to_hit;

    // to_cnt_q counts the earlier ACK-less ACTIVE cycles. This cycle is the
    // TIMEOUT_CYCLES-th one when the count equals TIMEOUT_CYCLES-1.
    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    assign req = m_read_i | m_write_i;

    // Round-robin search. Start at the master after the last winner and wrap
    // around. The last winner is examined last, so it cannot win again while
    // another master is waiting.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the fields of the winning master.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_idx == PTR_W'(i)) begin
                sel_addr  = m_addr_i[32*i +: 32];
                sel_wdata = m_wdata_i[32*i +: 32];
                sel_read  = m_read_i[i];
                sel_write = m_write_i[i];
            end
        end
    end

    // Next-state and output logic. By default every register holds its value.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_read_d  = s_read_q;
        s_write_d = s_write_q;
        m_rdata_d = m_rdata_q;
        m_ack_d   = m_ack_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
`ifdef IO_BUS_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        m_err_d   = m_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    s_addr_d  = sel_addr;
                    s_wdata_d = sel_wdata;
                    // When read and write are both set, the write wins.
                    s_write_d = sel_write;
                    s_read_d  = sel_read & ~sel_write;
                    grant_d   = NUM_MASTERS'(1) << win_idx;
                    rr_ptr_d  = win_idx;
                    busy_d    = 1'b1;
                    state_d   = ST_ACTIVE;
`ifdef IO_BUS_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end
            end

            ST_ACTIVE: begin
                // Master inputs are not sampled here. The s_* outputs hold
                // until the slave acks. An ack in the same cycle as the
                // terminal count is a normal completion.
                if (s_ack_i) begin
                    m_rdata_d = s_rdata_i;
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    m_ack_d   = grant_q;
                    state_d   = ST_RESP;
`ifdef IO_BUS_TIMEOUT_EN
                end else if (to_hit) begin
                    m_rdata_d = 32'hDEAD_BEEF;
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    m_ack_d   = grant_q;
                    m_err_d   = grant_q;
                    state_d   = ST_RESP;
                end else begin
                    to_cnt_d  = to_cnt_q + TO_W'(1);
`endif
                end
            end

            ST_RESP: begin
                // The ack pulse is visible in this cycle. Requests seen here
                // are ignored; a request still high in IDLE is new work.
                m_ack_d   = '0;
                grant_d   = '0;
                s_addr_d  = '0;
                s_wdata_d = '0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
`ifdef IO_BUS_TIMEOUT_EN
                m_err_d   = '0;
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= PTR_W'(NUM_MASTERS - 1);
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_read_q  <= 1'b0;
            s_write_q <= 1'b0;
            m_rdata_q <= '0;
            m_ack_q   <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_read_q  <= s_read_d;
            s_write_q <= s_write_d;
            m_rdata_q <= m_rdata_d;
            m_ack_q   <= m_ack_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
        end
    end

`ifdef IO_BUS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            m_err_q  <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            m_err_q  <= m_err_d;
        end
    end

    assign m_err_o = m_err_q;
`else
    assign m_err_o = '0;
`endif

    assign m_rdata_o = m_rdata_q;
    assign m_ack_o   = m_ack_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;
    assign s_read_o  = s_read_q;
    assign s_write_o = s_write_q;
    assign grant_o   = grant_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_io_bus_arbiter
//
// Directed bench for io_bus_arbiter with two masters. Inputs are driven 1 ns
// after each rising edge, and outputs are sampled at the same point. "Cycle n"
// means the cycle after edge n, where edge 0 samples the request.
// ---------------------------------------------------------------------------
module tb_io_bus_arbiter;

  localparam int N = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  m_read_i;
  logic [N-1:0]  m_write_i;
  logic [N*32-1:0] m_addr_i;
  logic [N*32-1:0] m_wdata_i;
  logic [31:0]   m_rdata_o;
  logic [N-1:0]  m_ack_o;
  logic [N-1:0]  m_err_o;
  logic [31:0]   s_addr_o;
  logic [31:0]   s_wdata_o;
  logic          s_read_o;
  logic          s_write_o;
  logic [31:0]   s_rdata_i;
  logic          s_ack_i;
  logic [N-1:0]  grant_o;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  // Expected order of grants for the arbitration section.
  logic [N-1:0] exp_q[$];

  io_bus_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_read_i  (m_read_i),
    .m_write_i (m_write_i),
    .m_addr_i  (m_addr_i),
    .m_wdata_i (m_wdata_i),
    .m_rdata_o (m_rdata_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_addr_o  (s_addr_o),
    .s_wdata_o (s_wdata_o),
    .s_read_o  (s_read_o),
    .s_write_o (s_write_o),
    .s_rdata_i (s_rdata_i),
    .s_ack_i   (s_ack_i),
    .grant_o   (grant_o),
    .busy_o    (busy_o)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and move to the drive/sample point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_master(input int idx, input logic [31:0] addr, input logic [31:0] wdata);
    m_addr_i[32*idx +: 32]  = addr;
    m_wdata_i[32*idx +: 32] = wdata;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_grant_from_queue(input string tag);
    logic [N-1:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(grant_o), 32'(e));
  endtask

  initial begin
    rst       = 1'b1;
    m_read_i  = '0;
    m_write_i = '0;
    m_addr_i  = '0;
    m_wdata_i = '0;
    s_rdata_i = '0;
    s_ack_i   = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_ack", 32'(m_ack_o), 32'h0);
    check("rst_strobes", {30'h0, s_read_o, s_write_o}, 32'h0);
    check("rst_rdata", m_rdata_o, 32'h0);
    check("rst_saddr", s_addr_o, 32'h0);
    rst = 1'b0;

    // Single read from master 0, slave acks in cycle 3.
    set_master(0, 32'h4000_0010, 32'h0);
    m_read_i = 2'b01;
    tick();  // cycle 1
    check("rd_c1_sread", 32'(s_read_o), 32'h1);
    check("rd_c1_swrite", 32'(s_write_o), 32'h0);
    check("rd_c1_saddr", s_addr_o, 32'h4000_0010);
    check("rd_c1_grant", 32'(grant_o), 32'h1);
    check("rd_c1_busy", 32'(busy_o), 32'h1);
    check("rd_c1_ack", 32'(m_ack_o), 32'h0);
    tick();  // cycle 2
    check("rd_c2_sread", 32'(s_read_o), 32'h1);
    tick();  // cycle 3
    check("rd_c3_sread", 32'(s_read_o), 32'h1);
    s_ack_i   = 1'b1;
    s_rdata_i = 32'h1234_5678;
    tick();  // cycle 4
    check("rd_c4_ack", 32'(m_ack_o), 32'h1);
    check("rd_c4_err", 32'(m_err_o), 32'h0);
    check("rd_c4_rdata", m_rdata_o, 32'h1234_5678);
    check("rd_c4_sread", 32'(s_read_o), 32'h0);
    check("rd_c4_busy", 32'(busy_o), 32'h1);
    s_ack_i  = 1'b0;
    m_read_i = 2'b00;
    tick();  // cycle 5
    check("rd_c5_grant", 32'(grant_o), 32'h0);
    check("rd_c5_ack", 32'(m_ack_o), 32'h0);
    check("rd_c5_busy", 32'(busy_o), 32'h0);
    check("rd_c5_saddr", s_addr_o, 32'h0);
    check("rd_c5_rdata_hold", m_rdata_o, 32'h1234_5678);

    // A slave ack while IDLE is ignored.
    s_ack_i   = 1'b1;
    s_rdata_i = 32'hFFFF_FFFF;
    tick();
    check("idle_sack_ack", 32'(m_ack_o), 32'h0);
    check("idle_sack_rdata", m_rdata_o, 32'h1234_5678);
    check("idle_sack_grant", 32'(grant_o), 32'h0);
    s_ack_i = 1'b0;

    // Simultaneous writes after reset, then master 0 re-requests at once.
    do_reset();
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    set_master(0, 32'h4000_0100, 32'h1111_1111);
    set_master(1, 32'h4000_0200, 32'h2222_2222);
    m_write_i = 2'b11;
    tick();  // cycle 1: master 0
    check_grant_from_queue("sim_grant_first");
    check("sim_c1_saddr", s_addr_o, 32'h4000_0100);
    check("sim_c1_swdata", s_wdata_o, 32'h1111_1111);
    check("sim_c1_swrite", 32'(s_write_o), 32'h1);
    s_ack_i = 1'b1;
    tick();  // cycle 2: RESP
    check("sim_c2_ack", 32'(m_ack_o), 32'h1);
    check("sim_c2_swrite", 32'(s_write_o), 32'h0);
    s_ack_i   = 1'b0;
    m_write_i = 2'b10;
    tick();  // cycle 3: IDLE, master 0 raises a new write
    check("sim_c3_grant", 32'(grant_o), 32'h0);
    set_master(0, 32'h4000_0104, 32'h3333_3333);
    m_write_i = 2'b11;
    tick();  // cycle 4: master 1 must win
    check_grant_from_queue("b2b_grant_second");
    check("b2b_c4_saddr", s_addr_o, 32'h4000_0200);
    check("b2b_c4_swdata", s_wdata_o, 32'h2222_2222);
    s_ack_i = 1'b1;
    tick();  // cycle 5
    check("b2b_c5_ack", 32'(m_ack_o), 32'h2);
    s_ack_i   = 1'b0;
    m_write_i = 2'b01;
    tick();  // cycle 6
    check("b2b_c6_grant", 32'(grant_o), 32'h0);
    tick();  // cycle 7: master 0 second write
    check_grant_from_queue("b2b_grant_third");
    check("b2b_c7_saddr", s_addr_o, 32'h4000_0104);
    check("b2b_c7_swdata", s_wdata_o, 32'h3333_3333);
    s_ack_i = 1'b1;
    tick();  // cycle 8
    check("b2b_c8_ack", 32'(m_ack_o), 32'h1);
    s_ack_i   = 1'b0;
    m_write_i = 2'b00;
    tick();  // cycle 9
    check("b2b_c9_busy", 32'(busy_o), 32'h0);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'h0);

    // Read and write both high on master 1: write only. The master then
    // illegally drops its request during ACTIVE; the arbiter still completes it.
    set_master(1, 32'h4000_0300, 32'hA5A5_A5A5);
    m_read_i  = 2'b10;
    m_write_i = 2'b10;
    tick();
    check("rw_grant", 32'(grant_o), 32'h2);
    check("rw_swrite", 32'(s_write_o), 32'h1);
    check("rw_sread", 32'(s_read_o), 32'h0);
    check("rw_swdata", s_wdata_o, 32'hA5A5_A5A5);
    check("rw_saddr", s_addr_o, 32'h4000_0300);
    m_read_i  = 2'b00;
    m_write_i = 2'b00;
    tick();
    check("drop_swrite_held", 32'(s_write_o), 32'h1);
    check("drop_saddr_held", s_addr_o, 32'h4000_0300);
    s_ack_i   = 1'b1;
    s_rdata_i = 32'hCAFE_F00D;
    tick();
    check("drop_ack", 32'(m_ack_o), 32'h2);
    check("wr_rdata_capture", m_rdata_o, 32'hCAFE_F00D);
    s_ack_i = 1'b0;
    tick();
    check("drop_idle_busy", 32'(busy_o), 32'h0);

`ifdef IO_BUS_TIMEOUT_EN
    // The slave never acks; the timeout completes with an error in cycle 5.
    set_master(0, 32'h4000_0500, 32'h0);
    m_read_i = 2'b01;
    tick();
    cyc = 1;
    while (m_ack_o == '0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("to_latency", 32'(cyc), 32'd5);
    check("to_ack", 32'(m_ack_o), 32'h1);
    check("to_err", 32'(m_err_o), 32'h1);
    check("to_rdata", m_rdata_o, 32'hDEAD_BEEF);
    check("to_sread", 32'(s_read_o), 32'h0);
    m_read_i = 2'b00;
    tick();
    check("to_ack_clear", 32'(m_ack_o), 32'h0);
    check("to_err_clear", 32'(m_err_o), 32'h0);
    check("to_idle_grant", 32'(grant_o), 32'h0);
`endif

    // Reset in cycle 2 of a transaction with a coincident slave ack.
    set_master(0, 32'h4000_0400, 32'h0);
    m_read_i = 2'b01;
    tick();  // cycle 1
    check("rsta_c1_grant", 32'(grant_o), 32'h1);
    tick();  // cycle 2
    rst       = 1'b1;
    s_ack_i   = 1'b1;
    s_rdata_i = 32'h5555_AAAA;
    tick();
    check("rsta_ack", 32'(m_ack_o), 32'h0);
    check("rsta_grant", 32'(grant_o), 32'h0);
    check("rsta_sread", 32'(s_read_o), 32'h0);
    check("rsta_saddr", s_addr_o, 32'h0);
    check("rsta_busy", 32'(busy_o), 32'h0);
    check("rsta_rdata", m_rdata_o, 32'h0);
    rst     = 1'b0;
    s_ack_i = 1'b0;
    set_master(1, 32'h4000_0404, 32'h0);
    m_read_i = 2'b11;
    tick();
    check("rsta_next_grant", 32'(grant_o), 32'h1);
    check("rsta_next_saddr", s_addr_o, 32'h4000_0400);
    s_ack_i   = 1'b1;
    s_rdata_i = 32'h0BAD_CAFE;
    tick();
    check("rsta_next_ack", 32'(m_ack_o), 32'h1);
    check("rsta_next_rdata", m_rdata_o, 32'h0BAD_CAFE);
    s_ack_i  = 1'b0;
    m_read_i = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single memory-mapped IO bus (0x40000xxx space) between multiple bus masters: CPU memory stage (master 0), bootloader (master 1) and future masters such as DMA.
- Replaces tri-state bus sharing with a registered round-robin arbiter.
- Each master holds read/write until acked; the arbiter serialises transactions to one slave port and routes ack/read data back to the winner.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- TIMEOUT_CYCLES, 255, cycles in ACTIVE without slave ack before error completion (optional feature only)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- m_read_i  input  NUM_MASTERS  per-master read request, held until m_ack_o
- m_write_i  input  NUM_MASTERS  per-master write request, held until m_ack_o
- m_addr_i  input  NUM_MASTERS*32  per-master address, master i at [32*i+31:32*i]
- m_wdata_i  input  NUM_MASTERS*32  per-master write data, same packing
- m_rdata_o  output  32  read data, shared by all masters, valid with m_ack_o
- m_ack_o  output  NUM_MASTERS  one-cycle completion pulse to the winning master
- m_err_o  output  NUM_MASTERS  one-cycle error pulse, coincident with m_ack_o
- s_addr_o  output  32  slave bus address
- s_wdata_o  output  32  slave bus write data
- s_read_o  output  1  slave bus read strobe
- s_write_o  output  1  slave bus write strobe
- s_rdata_i  input  32  slave read data, valid with s_ack_i
- s_ack_i  input  1  slave acknowledge
- grant_o  output  NUM_MASTERS  one-hot current owner; 0 in IDLE
- busy_o  output  1  high in ACTIVE and RESP

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high.
- All outputs are registered. Reset applies at the next clk edge with rst=1.
- Reset values: state IDLE, all outputs 0, rr_ptr = NUM_MASTERS-1, so master 0 has top priority first.
- A request from master i is req[i] = m_read_i[i] | m_write_i[i].

FSM:
- IDLE:
  - If any req, pick the winner: the first requesting index searching from rr_ptr+1 upward, mod NUM_MASTERS.
  - Latch the winner's address, wdata and op into s_addr_o, s_wdata_o, s_read_o/s_write_o.
  - Set grant_o, set rr_ptr = winner, go to ACTIVE.
  - If read and write are both high, issue a write only.
- ACTIVE:
  - s_* outputs are held stable; no re-sampling of master inputs.
  - On s_ack_i=1: capture s_rdata_i into m_rdata_o (write: capture anyway, content don't-care).
  - Drop s_read_o/s_write_o, pulse m_ack_o[winner], go to RESP.
- RESP:
  - m_ack_o pulse is visible this cycle.
  - Next edge: clear m_ack_o, m_err_o, grant_o, s_addr_o and s_wdata_o; go to IDLE.
  - Requests seen in RESP are ignored.

Timing and latency:
- Request sampled at edge 0 gives s_read_o/s_write_o high after edge 0 (cycle 1).
- With s_ack_i in cycle 1, m_ack_o is high in cycle 2. Minimum request-to-ack is 2 cycles.
- Bus occupancy is ack latency + 2 cycles.
- A master must drop its request the cycle after m_ack_o. A request still high in IDLE is a new transaction.

Boundary conditions:
- Simultaneous requests: round-robin order. A master is never granted twice while another is waiting.
- A master dropping its request during ACTIVE is illegal; the arbiter completes the transaction and still pulses ack.
- s_ack_i outside ACTIVE is ignored.
- rst asserted mid-ACTIVE: the transaction is abandoned, no ack is issued, and all outputs are 0 after the edge.
- m_rdata_o holds its value until the next capture.

Optional Feature:
- Macro: IO_BUS_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to ACTIVE and increments each ACTIVE cycle without s_ack_i.
  - When the count reaches TIMEOUT_CYCLES, drop the strobes and set m_rdata_o = 32'hDEADBEEF.
  - Pulse m_ack_o[winner] and m_err_o[winner] together, then go to RESP.
  - s_ack_i in the same cycle as the terminal count wins: normal completion, no error.
- Undefined: ACTIVE waits indefinitely, m_err_o is tied 0, and no counter logic exists.

Test Plan:
- Single read: m_read_i=01, m_addr_i[0]=0x40000010, s_ack_i in cycle 3 with s_rdata_i=0x12345678 -> s_addr_o=0x40000010, s_read_o cycles 1-3, m_ack_o=01 and m_rdata_o=0x12345678 in cycle 4, grant_o=00 in cycle 5.
- Simultaneous: after reset, m_write_i=11 with 1-cycle slave ack -> master 0 served first; master 1 granted on the next IDLE cycle; never master 0 twice in a row.
- Back-to-back: master 0 re-requests immediately after its ack while master 1 is waiting -> master 1 is served before master 0's second transaction.
- Read+write both high from master 1 with wdata 0xA5A5A5A5 -> s_write_o=1, s_read_o=0, s_wdata_o=0xA5A5A5A5.
- Reset in ACTIVE: rst=1 in cycle 2 of a transaction, then s_ack_i=1 -> no m_ack_o pulse, all outputs 0, next grant goes to master 0.
- IO_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> m_ack_o and m_err_o pulse together for one cycle, m_rdata_o=0xDEADBEEF, FSM back to IDLE.
